// File: rtl/egg_feeder.sv
// egg_feeder: nonce-sweeping job dispatcher for the egg hashing core.
// Launches one core run per nonce and reports hashes below the target.
module egg_feeder #(
  parameter int unsigned TIMEOUT = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [511:0] job_header,
  input  logic [255:0] job_target,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic         abort,
  output logic         core_start,
  output logic [511:0] core_header,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         busy,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  attempts
);

  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CHECK,
    REPORT
  } state_t;

  state_t         state_q;
  logic [255:0]   target_q;
  logic [255:0]   hash_q;
  logic [31:0]    nonce_q;
  logic [31:0]    end_q;
  logic [TW-1:0]  timer_q;
  logic           start_q;
  logic [511:0]   header_q;
  logic           fvalid_q;
  logic [31:0]    fnonce_q;
  logic [255:0]   fhash_q;
  logic           busy_q;
  logic           exh_q;
  logic           tout_q;
  logic [31:0]    attempts_q;

  logic [31:0]    nonce_d;
  logic [TW-1:0]  timer_d;
  logic [31:0]    attempts_d;
  logic           last;
  logic           hit;

  // Low header word is replaced by the nonce, so the input bits are dropped.
  logic           unused_hdr;
  assign unused_hdr = ^job_header[31:0];

  always_comb begin
    nonce_d    = nonce_q + 32'd1;
    timer_d    = timer_q + TW'(1);
    last       = (nonce_q == end_q);
    hit        = (hash_q < target_q);
    attempts_d = (attempts_q == '1) ? attempts_q
                                    : attempts_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      hash_q     <= '0;
      nonce_q    <= '0;
      end_q      <= '0;
      timer_q    <= '0;
      start_q    <= 1'b0;
      header_q   <= '0;
      fvalid_q   <= 1'b0;
      fnonce_q   <= '0;
      fhash_q    <= '0;
      busy_q     <= 1'b0;
      exh_q      <= 1'b0;
      tout_q     <= 1'b0;
      attempts_q <= '0;
    end else begin
      start_q <= 1'b0;
      exh_q   <= 1'b0;
      tout_q  <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q  <= IDLE;
        fvalid_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (job_valid && !abort) begin
              header_q   <= {job_header[511:32],
                             job_nonce_start};
              target_q   <= job_target;
              nonce_q    <= job_nonce_start;
              end_q      <= job_nonce_end;
              attempts_q <= '0;
              start_q    <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LAUNCH;
            end
          end
          LAUNCH: begin
            timer_q <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            if (core_done) begin
              hash_q     <= core_hash;
              attempts_q <= attempts_d;
              state_q    <= CHECK;
            end else if (timer_d == TW'(TIMEOUT)) begin
              tout_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              timer_q <= timer_d;
            end
          end
          CHECK: begin
            if (hit) begin
              fvalid_q <= 1'b1;
              fnonce_q <= nonce_q;
              fhash_q  <= hash_q;
              state_q  <= REPORT;
            end else if (last) begin
              exh_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              nonce_q        <= nonce_d;
              header_q[31:0] <= nonce_d;
              start_q        <= 1'b1;
              state_q        <= LAUNCH;
            end
          end
          REPORT: begin
            if (found_ready) begin
              fvalid_q <= 1'b0;
              if (last) begin
                exh_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                nonce_q        <= nonce_d;
                header_q[31:0] <= nonce_d;
                start_q        <= 1'b1;
                state_q        <= LAUNCH;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign job_ready   = (state_q == IDLE);
  assign core_start  = start_q;
  assign core_header = header_q;
  assign found_valid = fvalid_q;
  assign found_nonce = fnonce_q;
  assign found_hash  = fhash_q;
  assign busy        = busy_q;
  assign exhausted   = exh_q;
  assign timeout_err = tout_q;
  assign attempts    = attempts_q;

endmodule
